branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
Consumer end of the branch-prediction path. It records each prediction issued at decode in a small in-order queue and checks it against the actual outcome when the branch resolves in MEM. On a wrong prediction it raises a flush, supplies the corrected PC, and holds the flush for a programmable number of cycles. It also drives the training strobe back to the 2-bit predictor, so the predictor no longer has to infer resolution from branch-signal edges.

Parameters:
DEPTH, 2, in-flight prediction entries; power of two, minimum 2.
FLUSH_CYCLES, 2, cycles flush_out stays high per mispredict; minimum 1.
CNT_W, 32, width of statistics counters (optional feature only).

Ports:
clk  input  1  core clock; all logic on posedge.
reset  input  1  synchronous, active-high.
push_valid  input  1  decode issues a branch this cycle.
push_pred  input  1  predicted taken.
push_target  input  32  taken-path PC (branch_addr).
push_fallthru  input  32  not-taken PC (pc+4).
resolve_valid  input  1  MEM resolves the oldest branch.
resolve_taken  input  1  actual branch decision.
flush_out  output  1  squash younger pipeline stages.
redirect_valid  output  1  one-cycle pulse: load redirect_pc into PC.
redirect_pc  output  32  corrected PC.
update_valid  output  1  one-cycle predictor training strobe.
update_taken  output  1  outcome to train with.
occupancy  output  $clog2(DEPTH)+1  current entry count.
err_overflow  output  1  sticky; push while full.
err_underflow  output  1  sticky; resolve while empty.

Behaviour:
- Reset: queue empty, occupancy 0, FSM in IDLE, all outputs 0, redirect_pc 0. Reset asserted mid-flush returns to IDLE on the next edge.
- Queue: circular FIFO, DEPTH entries of {pred, target, fallthru}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Push and resolve in the same cycle are both honoured; occupancy is unchanged.
- Resolve (queue non-empty): pop the head and compare resolve_taken with the stored pred.
  - Next cycle: update_valid=1 and update_taken=resolve_taken. Latency is 1 cycle, whether or not the prediction was correct.
  - On a mismatch, also in the next cycle: redirect_valid=1 for 1 cycle, and redirect_pc = target if resolve_taken else fallthru.
- Resolve while empty: ignored, err_underflow set, no update.
- Push while full (and no resolve in the same cycle): entry dropped, err_overflow set.
- FSM states IDLE and FLUSH:
  - IDLE -> FLUSH on a mismatch. The flush counter loads FLUSH_CYCLES-1, and flush_out=1 from the next cycle.
  - FLUSH: counter decrements each cycle; -> IDLE when the counter reaches 0. flush_out is high for exactly FLUSH_CYCLES cycles.
  - In the mismatch cycle, every younger queue entry is discarded (wrong path): occupancy becomes 0, and a same-cycle push is dropped without raising an error.
  - While in FLUSH, push_valid is ignored (wrong path). resolve_valid in FLUSH is treated as normal. A new mismatch in FLUSH reloads the counter.
- Error flags clear only on reset.

Optional Feature:
BRANCH_RESOLVER_STATS_EN.
- Defined: adds output ports stat_branches[CNT_W] and stat_mispredicts[CNT_W]. They count valid resolves and mismatches, saturate at all-ones, and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines header holds:
  - the entry field offsets (PRED bit, TARGET and FALLTHRU slices) and the entry width constant of 65 bits;
  - FSM state encodings (IDLE=1'b0, FLUSH=1'b1).
- Sub-module branch_resolver_fifo: parameterised synchronous FIFO with push, pop, clear, full, empty and count. The FSM, compare and redirect logic stay in the top level.

Test Plan:
- Push pred=1, target=0x100, fallthru=0x084; resolve taken=1 three cycles later -> update_valid=1, update_taken=1 the next cycle; no redirect, no flush.
- Push pred=1, target=0x200, fallthru=0x010; resolve taken=0 -> next cycle redirect_valid=1 with redirect_pc=0x010, flush_out high exactly 2 cycles, occupancy=0.
- Push pred=0 twice (DEPTH=2), then push a third -> occupancy stays 2, err_overflow=1 sticky. Resolve twice -> both correct in FIFO order, occupancy 0.
- Resolve with empty queue -> err_underflow=1, update_valid stays 0.
- Mismatch while a push is asserted in the same cycle and during FLUSH -> pushes dropped, occupancy 0 after flush, err_overflow unchanged.
- Assert reset in the 1st FLUSH cycle -> flush_out=0 next cycle, FSM IDLE, flags and occupancy 0. With BRANCH_RESOLVER_STATS_EN, 3 resolves including 1 mismatch -> stat_branches=3, stat_mispredicts=1.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: queue entry layout and resolver FSM encodings
package branch_resolver_pkg;
  localparam int ENTRY_W = 65;
  localparam int PRED_BIT = 64;
  localparam int TARGET_HI = 63;
  localparam int TARGET_LO = 32;
  localparam int FALLTHRU_HI = 31;
  localparam int FALLTHRU_LO = 0;
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;
endpackage

// File: rtl/branch_resolver_fifo.sv
// branch_resolver_fifo: in-order prediction queue with synchronous clear
module branch_resolver_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: checks predictions at resolve, redirects/flushes on mismatch, trains predictor (BRANCH_RESOLVER_STATS_EN adds counters)
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_valid,
  input  logic                   push_pred,
  input  logic [31:0]            push_target,
  input  logic [31:0]            push_fallthru,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  output logic                   flush_out,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   update_valid,
  output logic                   update_taken,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_overflow,
  output logic                   err_underflow
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [CNT_W-1:0]       stat_branches,
  output logic [CNT_W-1:0]       stat_mispredicts
`endif
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  logic [ENTRY_W-1:0] head;
  logic full, empty, do_pop, do_push, mismatch;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  assign do_pop = resolve_valid & ~empty;
  assign mismatch = do_pop & (resolve_taken != head[PRED_BIT]);
  assign do_push = push_valid & (state == IDLE) & ~mismatch;
  branch_resolver_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(do_push),
    .pop(do_pop),
    .clear(mismatch),
    .din({push_pred, push_target, push_fallthru}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(occupancy)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= mismatch ? CW'(FLUSH_CYCLES - 1) : (state == FLUSH && cnt != '0) ? cnt - 1'b1 : cnt;
    end
  end
  always_comb begin
    state_nx = mismatch ? FLUSH : (state == FLUSH && cnt == '0) ? IDLE : state;
  end
  always_comb begin
    flush_out = state == FLUSH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      update_valid <= 1'b0;
      update_taken <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      update_valid <= do_pop;
      update_taken <= do_pop & resolve_taken;
      redirect_valid <= mismatch;
      if (mismatch) redirect_pc <= resolve_taken ? head[TARGET_HI:TARGET_LO] : head[FALLTHRU_HI:FALLTHRU_LO];
      err_overflow <= err_overflow | (push_valid & (state == IDLE) & full & ~resolve_valid);
      err_underflow <= err_underflow | (resolve_valid & empty);
    end
  end
`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_pop && stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (mismatch && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: table-driven directed check of branch_resolver (DEPTH=2, FLUSH_CYCLES=2)
module tb_branch_resolver;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic push_valid = 1'b0, push_pred = 1'b0, resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic [31:0] push_target = '0, push_fallthru = '0;
  logic flush_out, redirect_valid, update_valid, update_taken, err_overflow, err_underflow;
  logic [31:0] redirect_pc;
  logic [1:0] occupancy;
  int errors = 0;
  int checks = 0;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif
  branch_resolver #(.DEPTH(2), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .push_valid(push_valid),
    .push_pred(push_pred),
    .push_target(push_target),
    .push_fallthru(push_fallthru),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .flush_out(flush_out),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .update_valid(update_valid),
    .update_taken(update_taken),
    .occupancy(occupancy),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic pv, pp;
    logic [31:0] pt, pf;
    logic rv, rt;
    logic fl, rdv;
    logic [31:0] rpc;
    logic uv, ut;
    logic [1:0] occ;
    logic eo, eu;
  } vec_t;
  vec_t v [23];
  task automatic drive(input logic pv, input logic pp, input logic [31:0] pt, input logic [31:0] pf, input logic rv, input logic rt);
    @(negedge clk);
    push_valid = pv;
    push_pred = pp;
    push_target = pt;
    push_fallthru = pf;
    resolve_valid = rv;
    resolve_taken = rt;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got fl/rdv/pc/uv/ut/occ/eo/eu=%b/%b/%h/%b/%b/%0d/%b/%b required %b/%b/%h/%b/%b/%0d/%b/%b", name,
               act[39], act[38], act[37:6], act[5], act[4], act[3:2], act[1], act[0],
               exp[39], exp[38], exp[37:6], exp[5], exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask
  function automatic logic [39:0] outs();
    return {flush_out, redirect_valid, redirect_pc, update_valid, update_taken, occupancy, err_overflow, err_underflow};
  endfunction
  initial begin
    v[0]  = '{H, H, 32'h100, 32'h084, L, L,  L, L, 32'h000, L, L, 2'd1, L, L};
    v[1]  = '{L, L, 32'h000, 32'h000, L, L,  L, L, 32'h000, L, L, 2'd1, L, L};
    v[2]  = '{L, L, 32'h000, 32'h000, L, L,  L, L, 32'h000, L, L, 2'd1, L, L};
    v[3]  = '{L, L, 32'h000, 32'h000, H, H,  L, L, 32'h000, H, H, 2'd0, L, L};
    v[4]  = '{L, L, 32'h000, 32'h000, L, L,  L, L, 32'h000, L, L, 2'd0, L, L};
    v[5]  = '{H, H, 32'h200, 32'h010, L, L,  L, L, 32'h000, L, L, 2'd1, L, L};
    v[6]  = '{L, L, 32'h000, 32'h000, H, L,  H, H, 32'h010, H, L, 2'd0, L, L};
    v[7]  = '{L, L, 32'h000, 32'h000, L, L,  H, L, 32'h010, L, L, 2'd0, L, L};
    v[8]  = '{L, L, 32'h000, 32'h000, L, L,  L, L, 32'h010, L, L, 2'd0, L, L};
    v[9]  = '{H, L, 32'h300, 32'h304, L, L,  L, L, 32'h010, L, L, 2'd1, L, L};
    v[10] = '{H, L, 32'h400, 32'h404, L, L,  L, L, 32'h010, L, L, 2'd2, L, L};
    v[11] = '{H, H, 32'h500, 32'h504, L, L,  L, L, 32'h010, L, L, 2'd2, H, L};
    v[12] = '{L, L, 32'h000, 32'h000, H, L,  L, L, 32'h010, H, L, 2'd1, H, L};
    v[13] = '{L, L, 32'h000, 32'h000, H, L,  L, L, 32'h010, H, L, 2'd0, H, L};
    v[14] = '{L, L, 32'h000, 32'h000, H, H,  L, L, 32'h010, L, L, 2'd0, H, H};
    v[15] = '{H, L, 32'h600, 32'h604, L, L,  L, L, 32'h010, L, L, 2'd1, H, H};
    v[16] = '{H, H, 32'h700, 32'h704, H, H,  H, H, 32'h600, H, H, 2'd0, H, H};
    v[17] = '{H, L, 32'h800, 32'h804, L, L,  H, L, 32'h600, L, L, 2'd0, H, H};
    v[18] = '{H, L, 32'h900, 32'h904, L, L,  L, L, 32'h600, L, L, 2'd0, H, H};
    v[19] = '{L, L, 32'h000, 32'h000, L, L,  L, L, 32'h600, L, L, 2'd0, H, H};
    v[20] = '{H, H, 32'hA00, 32'hA04, L, L,  L, L, 32'h600, L, L, 2'd1, H, H};
    v[21] = '{H, L, 32'hB00, 32'hB04, H, H,  L, L, 32'h600, H, H, 2'd1, H, H};
    v[22] = '{L, L, 32'h000, 32'h000, H, H,  H, H, 32'hB00, H, H, 2'd0, H, H};
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs(), 40'h0);
    drive(L, L, 32'h0, 32'h0, L, L);
    reset = 1'b0;
    for (int i = 0; i < 23; i++) begin
      drive(v[i].pv, v[i].pp, v[i].pt, v[i].pf, v[i].rv, v[i].rt);
      check($sformatf("vec%0d", i), outs(),
            {v[i].fl, v[i].rdv, v[i].rpc, v[i].uv, v[i].ut, v[i].occ, v[i].eo, v[i].eu});
    end
    @(negedge clk);
    check("flush_first_cycle", outs(), {H, H, 32'hB00, H, H, 2'd0, H, H});
    reset = 1'b1;
    push_valid = 1'b0;
    resolve_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_flush", outs(), 40'h0);
    drive(L, L, 32'h0, 32'h0, L, L);
    check("idle_after_reset", outs(), 40'h0);
    reset = 1'b0;
`ifdef BRANCH_RESOLVER_STATS_EN
    drive(H, L, 32'hC00, 32'hC04, L, L);
    drive(H, H, 32'hD00, 32'hD04, H, L);
    drive(L, L, 32'h0, 32'h0, H, L);
    drive(L, L, 32'h0, 32'h0, L, L);
    drive(L, L, 32'h0, 32'h0, L, L);
    drive(H, H, 32'hE00, 32'hE04, L, L);
    drive(L, L, 32'h0, 32'h0, H, H);
    checks++;
    if (stat_branches !== 32'd3 || stat_mispredicts !== 32'd1) begin
      errors++;
      $display("FAIL stats: got branches=%0d mispredicts=%0d required 3/1", stat_branches, stat_mispredicts);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
